// File: rtl/secure_decryption_module_if.sv
// Valid/ready word stream between the ciphertext link, the decryptor and the consumer.
interface secure_decryption_module_if #(
    parameter int N = 8
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/secure_decryption_module.sv
// Streaming decryptor: plain = cipher ^ key, with FSM-controlled rekeying and a word counter.
// Optional rolling key (rotate left after each accepted word) when DECRYPT_ROLL_EN is defined.
module secure_decryption_module #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_key_load,
    input  logic [N-1:0]         i_key_in,
    output logic                 o_key_valid,
    output logic [CNT_W-1:0]     o_word_count,
    secure_decryption_module_if.slave  s_if,
    secure_decryption_module_if.master m_if
);

    typedef enum logic [1:0] {
        S_NOKEY = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_key;
    logic [N-1:0]     r_pend;
    logic [N-1:0]     r_m_data;
    logic             r_m_valid;
    logic             r_key_valid;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s_ready;
    logic             w_accept;
    logic             w_hs;
    logic [N-1:0]     w_key_adv;
    logic [N-1:0]     w_pend_nxt;

    assign w_s_ready  = (r_state == S_RUN) && (!r_m_valid || m_if.ready);
    assign w_accept   = s_if.valid && w_s_ready;
    assign w_hs       = r_m_valid && m_if.ready;
    // In S_DRAIN a fresh request overrides the captured one, even on the exit cycle.
    assign w_pend_nxt = i_key_load ? i_key_in : r_pend;

`ifdef DECRYPT_ROLL_EN
    assign w_key_adv = {r_key[N-2:0], r_key[N-1]};
`else
    assign w_key_adv = r_key;
`endif

    // Later assignments in this block override the datapath updates: a key load beats the
    // rotate, and a counter clear beats the increment of a word accepted in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_NOKEY;
            r_key       <= '0;
            r_pend      <= '0;
            r_m_data    <= '0;
            r_m_valid   <= 1'b0;
            r_key_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_m_data  <= s_if.data ^ r_key;
                r_m_valid <= 1'b1;
                r_cnt     <= r_cnt + CNT_W'(1);
                r_key     <= w_key_adv;
            end else if (m_if.ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                S_NOKEY: begin
                    if (i_key_load) begin
                        r_key       <= i_key_in;
                        r_cnt       <= '0;
                        r_key_valid <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_key_load) begin
                        if (r_m_valid) begin
                            r_pend  <= i_key_in;
                            r_state <= S_DRAIN;
                        end else begin
                            r_key <= i_key_in;
                            r_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_pend <= w_pend_nxt;
                    if (!r_m_valid || w_hs) begin
                        r_key   <= w_pend_nxt;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state     <= S_NOKEY;
                    r_key_valid <= 1'b0;
                end
            endcase
        end
    end

    assign s_if.ready   = w_s_ready;
    assign m_if.valid   = r_m_valid;
    assign m_if.data    = r_m_data;
    assign o_key_valid  = r_key_valid;
    assign o_word_count = r_cnt;

endmodule

// File: tb/tb_secure_decryption_module.sv
// Randomized bench for secure_decryption_module with a cycle-level behavioural model and directed literal checks.
module tb_secure_decryption_module;
    localparam int N     = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_load = 1'b0;
    logic [N-1:0]     key_in = '0;
    logic             key_valid;
    logic [CNT_W-1:0] word_count;

    secure_decryption_module_if #(.N(N)) s_if ();
    secure_decryption_module_if #(.N(N)) m_if ();

    always #5 clk = ~clk;

    secure_decryption_module #(.N(N), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_load   (key_load),
        .i_key_in     (key_in),
        .o_key_valid  (key_valid),
        .o_word_count (word_count),
        .s_if         (s_if),
        .m_if         (m_if)
    );

    int checks = 0;
    int errors = 0;

    // Model of the block's observable state
    bit       md_ok = 0;
    bit       md_has_key, md_drain, md_mv;
    bit [7:0] md_key, md_pend, md_data;
    int       md_cnt;

    function automatic bit [7:0] rotl(input bit [7:0] k);
        return {k[6:0], k[7]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit exp_rdy;
        if (!md_ok) return;
        exp_rdy = md_has_key && !md_drain && (!md_mv || m_if.ready);
        chk("key_valid", {31'b0, key_valid}, {31'b0, md_has_key});
        chk("s_ready",   {31'b0, s_if.ready}, {31'b0, exp_rdy});
        chk("m_valid",   {31'b0, m_if.valid}, {31'b0, md_mv});
        chk("m_data",    {24'b0, m_if.data},  {24'b0, md_data});
        chk("word_count", {30'b0, word_count}, 32'(md_cnt % (1 << CNT_W)));
    endtask

    task automatic model_update();
        bit rdy, acc, old_mv, hs, mr;
        mr     = m_if.ready;
        rdy    = md_has_key && !md_drain && (!md_mv || mr);
        acc    = s_if.valid && rdy;
        old_mv = md_mv;
        hs     = old_mv && mr;
        if (!rst_n) begin
            md_has_key = 0; md_drain = 0; md_mv = 0;
            md_data = 0; md_key = 0; md_pend = 0; md_cnt = 0;
            md_ok = 1;
            return;
        end
        if (acc) begin
            md_data = s_if.data ^ md_key;
            md_mv   = 1;
            md_cnt  = md_cnt + 1;
`ifdef DECRYPT_ROLL_EN
            md_key  = rotl(md_key);
`endif
        end else if (mr) begin
            md_mv = 0;
        end
        if (!md_has_key) begin
            if (key_load) begin
                md_key = key_in; md_cnt = 0; md_has_key = 1;
            end
        end else if (!md_drain) begin
            if (key_load) begin
                if (old_mv) begin
                    md_pend = key_in; md_drain = 1;
                end else begin
                    md_key = key_in; md_cnt = 0;
                end
            end
        end else begin
            if (key_load) md_pend = key_in;
            if (!old_mv || hs) begin
                md_key = md_pend; md_cnt = 0; md_drain = 0;
            end
        end
    endtask

    // One clock: drive at negedge, compare, let the edge happen, advance the model.
    task automatic cyc(input bit kl, input bit [7:0] ki, input bit sv, input bit [7:0] sd, input bit mr);
        key_load     = kl;
        key_in       = ki;
        s_if.valid   = sv;
        s_if.data    = sd;
        m_if.ready   = mr;
        #1;
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        s_if.valid = 0; s_if.data = 0; m_if.ready = 0;

        rst_n = 0;
        cyc(0, 8'h00, 1, 8'h55, 1);
        cyc(0, 8'h00, 1, 8'h55, 1);
        rst_n = 1;
        #1;
        chk("rst_key_valid", {31'b0, key_valid}, 32'd0);
        chk("rst_m_valid", {31'b0, m_if.valid}, 32'd0);
        chk("rst_m_data", {24'b0, m_if.data}, 32'd0);
        chk("rst_count", {30'b0, word_count}, 32'd0);

        // Input offered with no key
        cyc(0, 8'h00, 1, 8'h55, 1);
        #1;
        chk("nokey_s_ready", {31'b0, s_if.ready}, 32'd0);
        chk("nokey_m_valid", {31'b0, m_if.valid}, 32'd0);
        chk("nokey_key_valid", {31'b0, key_valid}, 32'd0);

        cyc(1, 8'hA5, 0, 8'h00, 1);
        cyc(0, 8'h00, 1, 8'h3C, 1);
        #1;
        chk("a5_m_data", {24'b0, m_if.data}, 32'h99);
        chk("a5_m_valid", {31'b0, m_if.valid}, 32'd1);
        chk("a5_count", {30'b0, word_count}, 32'd1);
        cyc(0, 8'h00, 0, 8'h00, 1);

        // Backpressure with key 0xFF
        cyc(1, 8'hFF, 0, 8'h00, 1);
        cyc(0, 8'h00, 1, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 8'h00, 1, 8'h01, 0);
            #1;
            chk("bp_hold_data", {24'b0, m_if.data}, 32'hFF);
            chk("bp_s_ready", {31'b0, s_if.ready}, 32'd0);
        end
        cyc(0, 8'h00, 1, 8'h01, 1);
        #1;
        chk("bp_out2", {24'b0, m_if.data}, 32'hFE);
        cyc(0, 8'h00, 1, 8'h02, 1);
        #1;
        chk("bp_out3", {24'b0, m_if.data}, 32'hFD);
        cyc(0, 8'h00, 0, 8'h00, 1);

        // Rekey while output is stalled
        cyc(0, 8'h00, 1, 8'h11, 0);
        cyc(1, 8'h0F, 0, 8'h00, 0);
        #1;
        chk("drain_s_ready", {31'b0, s_if.ready}, 32'd0);
        chk("drain_key_valid", {31'b0, key_valid}, 32'd1);
        cyc(0, 8'h00, 0, 8'h00, 1);
        cyc(0, 8'h00, 1, 8'hF0, 1);
        #1;
        chk("rekey_m_data", {24'b0, m_if.data}, 32'hFF);
        chk("rekey_count", {30'b0, word_count}, 32'd1);
        cyc(0, 8'h00, 0, 8'h00, 1);

        // Rolling-key vector
        cyc(1, 8'h81, 0, 8'h00, 1);
        cyc(0, 8'h00, 1, 8'h81, 1);
        #1;
        chk("roll_w0", {24'b0, m_if.data}, 32'h00);
        cyc(0, 8'h00, 1, 8'h03, 1);
        #1;
`ifdef DECRYPT_ROLL_EN
        chk("roll_w1", {24'b0, m_if.data}, 32'h00);
`else
        chk("roll_w1", {24'b0, m_if.data}, 32'h82);
`endif
        cyc(0, 8'h00, 0, 8'h00, 1);

        // Counter wrap at CNT_W=2
        cyc(1, 8'h00, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 8'h00, 1, 8'(i), 1);
            #1;
            chk("cnt_wrap", {30'b0, word_count}, 32'((i + 1) % 4));
        end

        // Randomized traffic, rekeys and occasional mid-stream resets
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(($urandom_range(0, 7) == 0), 8'($urandom), $urandom_range(0, 3) != 0,
                8'($urandom), $urandom_range(0, 2) != 0);
        end
        rst_n = 1;
        cyc(0, 8'h00, 0, 8'h00, 1);
        cyc(0, 8'h00, 0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
